// File: rtl/traffic_pkg.sv
// Shared types and constants for the traffic light controller front end:
// demand FSM states, tick divider width and lamp bit positions.
package traffic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARMED   = 3'd1,
        SERVING = 3'd2,
        DRAIN   = 3'd3,
        HOLDOFF = 3'd4
    } demand_state_e;

    // Wide enough for a 1 s divider at 50 MHz.
    localparam int TICK_CNT_W = 26;

    localparam int LAMP_GREEN  = 0;
    localparam int LAMP_YELLOW = 1;
    localparam int LAMP_RED    = 2;

    // Demand is asserted from arming until the side-street red has been covered.
    function automatic logic demand_active(input demand_state_e s);
        return (s == ARMED) || (s == SERVING) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/vehicle_demand_conditioner_if.sv
// Signal bundle between the loop/lamp side of the system and the demand conditioner.
interface vehicle_demand_conditioner_if;

    logic       raw_loop;
    logic       side_green;
    logic       sensor;
    logic       sec_tick;
    logic [7:0] vehicle_count;
    logic [2:0] demand_state;

    modport master (
        output raw_loop,
        output side_green,
        input  sensor,
        input  sec_tick,
        input  vehicle_count,
        input  demand_state
    );

    modport slave (
        input  raw_loop,
        input  side_green,
        output sensor,
        output sec_tick,
        output vehicle_count,
        output demand_state
    );

endinterface

// File: rtl/loop_debouncer.sv
// Two-flop synchroniser and stability-count debouncer for the loop detector,
// with a one-cycle pulse on each debounced rising edge.
module loop_debouncer #(
    parameter int DEBOUNCE_CYC = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic loop_clean,
    output logic loop_rise
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;

    always_comb begin
        sync1_d = raw_in;
        sync2_d = sync1_q;
        cnt_d   = '0;
        clean_d = clean_q;
        // The count only advances while the input disagrees; any agreement restarts it.
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        rise_d = clean_d & ~clean_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
        end
    end

    assign loop_clean = clean_q;
    assign loop_rise  = rise_q;

endmodule

// File: rtl/vehicle_demand_conditioner.sv
// Side-street demand conditioner: debounced loop input, 1 s tick divider, arrival
// counter and the demand FSM that holds 'sensor' through the whole side-street sequence.
module vehicle_demand_conditioner
    import traffic_pkg::*;
#(
    parameter int TICK_DIV     = 50_000_000,
    parameter int DEBOUNCE_CYC = 16,
    parameter int DRAIN_SEC    = 8,
    parameter int HOLDOFF_SEC  = 5
) (
    input logic                         clk,
    input logic                         reset,
    vehicle_demand_conditioner_if.slave bus
);

    localparam int SEC_MAX = (DRAIN_SEC > HOLDOFF_SEC) ? DRAIN_SEC : HOLDOFF_SEC;
    localparam int SEC_W   = $clog2(SEC_MAX + 1);

    localparam logic [TICK_CNT_W-1:0] DIV_LAST   = TICK_CNT_W'(TICK_DIV - 1);
    localparam logic [SEC_W-1:0]      DRAIN_LAST = SEC_W'(DRAIN_SEC - 1);
    localparam logic [SEC_W-1:0]      HOLD_LAST  = SEC_W'(HOLDOFF_SEC - 1);

    logic loop_clean;
    logic loop_rise;

    logic                  sg_sync1_q, sg_sync1_d;
    logic                  sg_sync2_q, sg_sync2_d;
    logic [TICK_CNT_W-1:0] div_q, div_d;
    logic [7:0]            count_q, count_d;
    logic [SEC_W-1:0]      sec_q, sec_d;
    demand_state_e         state_q, state_d;
    logic                  tick;

    loop_debouncer #(
        .DEBOUNCE_CYC (DEBOUNCE_CYC)
    ) u_debounce (
        .clk        (clk),
        .reset      (reset),
        .raw_in     (bus.raw_loop),
        .loop_clean (loop_clean),
        .loop_rise  (loop_rise)
    );

    always_comb begin
        sg_sync1_d = bus.side_green;
        sg_sync2_d = sg_sync1_q;

        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + TICK_CNT_W'(1);

        count_d = count_q;
        if (loop_rise && (count_q != 8'hFF)) begin
            count_d = count_q + 8'd1;
        end

        // The sec counter is cleared on every entry to a timed state, so a tick
        // coinciding with the entry edge is never counted.
        state_d = state_q;
        sec_d   = sec_q;
        case (state_q)
            IDLE: begin
                if (sg_sync2_q) begin
                    state_d = SERVING;
                end else if (loop_rise) begin
                    state_d = ARMED;
                end
            end
            ARMED: begin
                if (sg_sync2_q) begin
                    state_d = SERVING;
                end
            end
            SERVING: begin
                if (!sg_sync2_q) begin
                    state_d = DRAIN;
                    sec_d   = '0;
                end
            end
            DRAIN: begin
                if (tick) begin
                    if (sec_q == DRAIN_LAST) begin
                        state_d = HOLDOFF;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
            end
            HOLDOFF: begin
                if (tick) begin
                    if (sec_q == HOLD_LAST) begin
                        state_d = loop_clean ? ARMED : IDLE;
                        sec_d   = '0;
                    end else begin
                        sec_d = sec_q + SEC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                sec_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sg_sync1_q <= 1'b0;
            sg_sync2_q <= 1'b0;
            div_q      <= '0;
            count_q    <= '0;
            sec_q      <= '0;
            state_q    <= IDLE;
        end else begin
            sg_sync1_q <= sg_sync1_d;
            sg_sync2_q <= sg_sync2_d;
            div_q      <= div_d;
            count_q    <= count_d;
            sec_q      <= sec_d;
            state_q    <= state_d;
        end
    end

    assign bus.sensor        = demand_active(state_q);
    assign bus.sec_tick      = tick;
    assign bus.vehicle_count = count_q;
    assign bus.demand_state  = state_q;

endmodule

// File: tb/tb_vehicle_demand_conditioner.sv
// Self-checking bench for vehicle_demand_conditioner: directed scenarios plus random
// loop/lamp traffic, checked every cycle against a behavioural model.
module tb_vehicle_demand_conditioner;

    localparam int TICK_DIV     = 10;
    localparam int DEBOUNCE_CYC = 4;
    localparam int DRAIN_SEC    = 8;
    localparam int HOLDOFF_SEC  = 5;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    vehicle_demand_conditioner_if vif();

    vehicle_demand_conditioner #(
        .TICK_DIV     (TICK_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .DRAIN_SEC    (DRAIN_SEC),
        .HOLDOFF_SEC  (HOLDOFF_SEC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    always #5 clk = ~clk;

    // Model: mode 0..4 = idle/armed/serving/drain/holdoff; m_left counts remaining seconds.
    int m_cyc, m_mode, m_left, m_run, m_count;
    bit m_clean, m_rise;
    bit m_rawq[$];
    bit m_sgq[$];

    task automatic model_reset();
        m_cyc = 0; m_mode = 0; m_left = 0; m_run = 0; m_count = 0;
        m_clean = 1'b0; m_rise = 1'b0;
        m_rawq = '{1'b0, 1'b0};
        m_sgq  = '{1'b0, 1'b0};
    endtask

    task automatic model_step();
        bit tick_now, d, sg;
        if (reset) begin
            model_reset();
            return;
        end
        tick_now = (m_cyc % TICK_DIV) == TICK_DIV - 1;
        m_cyc++;
        d  = m_rawq.pop_front(); m_rawq.push_back(vif.raw_loop);
        sg = m_sgq.pop_front();  m_sgq.push_back(vif.side_green);
        case (m_mode)
            0: begin
                if (sg) m_mode = 2;
                else if (m_rise) m_mode = 1;
            end
            1: begin
                if (sg) m_mode = 2;
            end
            2: begin
                if (!sg) begin m_mode = 3; m_left = DRAIN_SEC; end
            end
            3: begin
                if (tick_now) begin
                    m_left--;
                    if (m_left == 0) begin m_mode = 4; m_left = HOLDOFF_SEC; end
                end
            end
            default: begin
                if (tick_now) begin
                    m_left--;
                    if (m_left == 0) m_mode = m_clean ? 1 : 0;
                end
            end
        endcase
        if (m_rise && m_count < 255) m_count++;
        m_rise = 1'b0;
        if (d != m_clean) begin
            m_run++;
            if (m_run == DEBOUNCE_CYC) begin
                m_clean = d;
                m_run   = 0;
                m_rise  = d;
            end
        end else begin
            m_run = 0;
        end
    endtask

    function automatic logic [12:0] exp_vec();
        logic s;
        s = (m_mode >= 1) && (m_mode <= 3);
        return {s, ((m_cyc % TICK_DIV) == TICK_DIV - 1), 3'(m_mode), 8'(m_count)};
    endfunction

    function automatic logic [12:0] obs_vec();
        return {vif.sensor, vif.sec_tick, vif.demand_state, vif.vehicle_count};
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        vif.raw_loop   = 1'b0;
        vif.side_green = 1'b0;
        model_reset();
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_vec() !== 13'd0) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h", obs_vec(), 13'd0);
        end
        $display("test_reset done");
    endtask

    task automatic test_tick_idle();
        int first = -1;
        int ticks = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL tick_idle_model cyc=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (vif.sec_tick === 1'b1) begin
                if (first < 0) first = i;
                ticks++;
            end
        end
        checks++;
        if (first != 9) begin
            failures++;
            $display("FAIL tick_first got=%0d exp=9", first);
        end
        checks++;
        if (ticks != 10) begin
            failures++;
            $display("FAIL tick_count got=%0d exp=10", ticks);
        end
        checks++;
        if (vif.sensor !== 1'b0 || vif.vehicle_count !== 8'd0) begin
            failures++;
            $display("FAIL tick_idle_quiet got sensor=%b count=%0d exp sensor=0 count=0",
                     vif.sensor, vif.vehicle_count);
        end
        $display("test_tick_idle done: first tick %0d, %0d ticks", first, ticks);
    endtask

    task automatic test_glitch();
        bit ever_high = 1'b0;
        for (int i = 0; i < 50; i++) begin
            vif.raw_loop = (i < 40) ? ~1'((i >> 1) & 1) : 1'b0;
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL glitch_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (vif.sensor === 1'b1) ever_high = 1'b1;
        end
        checks++;
        if (ever_high || vif.vehicle_count !== 8'd0) begin
            failures++;
            $display("FAIL glitch_reject got sensor_seen=%b count=%0d exp sensor_seen=0 count=0",
                     ever_high, vif.vehicle_count);
        end
        $display("test_glitch done");
    endtask

    task automatic test_arm();
        int lat = -1;
        vif.raw_loop = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL arm_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (lat < 0 && vif.sensor === 1'b1) lat = i;
        end
        checks++;
        if (lat != 7) begin
            failures++;
            $display("FAIL arm_latency got=%0d exp=7", lat);
        end
        checks++;
        if (vif.vehicle_count !== 8'd1 || vif.demand_state !== 3'd1) begin
            failures++;
            $display("FAIL arm_state got count=%0d state=%0d exp count=1 state=1",
                     vif.vehicle_count, vif.demand_state);
        end
        $display("test_arm done: latency %0d", lat);
    endtask

    task automatic test_service();
        int  drain_ticks = 0;
        int  hold_ticks  = 0;
        bit  in_hold = 1'b0;
        bit  done = 1'b0;
        bit  early_drop = 1'b0;
        vif.side_green = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL service_green_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
        end
        vif.side_green = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            step();
            checks++;
            if (obs_vec() !== exp_vec()) begin
                failures++;
                $display("FAIL service_drain_model i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
            end
            if (vif.demand_state === 3'd3 && vif.sec_tick === 1'b1) drain_ticks++;
            if (vif.demand_state === 3'd4) begin
                in_hold = 1'b1;
                if (vif.sec_tick === 1'b1) hold_ticks++;
            end else if (in_hold) begin
                done = 1'b1;
            end
            if (!in_hold && vif.sensor !== 1'b1) early_drop = 1'b1;
        end
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL service_timeout got=no_holdoff_exit exp=exit_within_400");
        end
        checks++;
        if (drain_ticks != DRAIN_SEC || early_drop) begin
            failures++;
            $display("FAIL service_drain got ticks=%0d early_drop=%b exp ticks=%0d early_drop=0",
                     drain_ticks, early_drop, DRAIN_SEC);
        end
        checks++;
        if (hold_ticks != HOLDOFF_SEC) begin
            failures++;
            $display("FAIL service_holdoff got=%0d exp=%0d", hold_ticks, HOLDOFF_SEC);
        end
        checks++;
        if (vif.sensor !== 1'b1 || vif.demand_state !== 3'd1) begin
            failures++;
            $display("FAIL service_rearm got sensor=%b state=%0d exp sensor=1 state=1",
                     vif.sensor, vif.demand_state);
        end
        $display("test_service done: drain %0d ticks, holdoff %0d ticks", drain_ticks, hold_ticks);
    endtask

    task automatic test_reset_in_drain();
        bit reached = 1'b0;
        vif.side_green = 1'b1;
        repeat (10) step();
        vif.side_green = 1'b0;
        for (int i = 0; i < 20 && !reached; i++) begin
            step();
            if (vif.demand_state === 3'd3) reached = 1'b1;
        end
        repeat (3) step();
        checks++;
        if (vif.demand_state !== 3'd3 || vif.sensor !== 1'b1) begin
            failures++;
            $display("FAIL drain_reached got state=%0d sensor=%b exp state=3 sensor=1",
                     vif.demand_state, vif.sensor);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== 13'd0) begin
            failures++;
            $display("FAIL reset_in_drain got=%h exp=%h", obs_vec(), 13'd0);
        end
        model_reset();
        step();
        step();
        vif.raw_loop = 1'b0;
        reset = 1'b0;
        $display("test_reset_in_drain done");
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 300; seg++) begin
            vif.raw_loop = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) vif.side_green = ~vif.side_green;
            for (int k = $urandom_range(1, 12); k > 0; k--) begin
                step();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL random_model seg=%0d got=%h exp=%h", seg, obs_vec(), exp_vec());
                end
            end
        end
        $display("test_random done: count %0d", vif.vehicle_count);
    endtask

    task automatic test_saturate();
        do_reset();
        for (int a = 0; a < 300; a++) begin
            vif.raw_loop = 1'b1;
            repeat (DEBOUNCE_CYC + $urandom_range(0, 3)) begin
                step();
                checks++;
                if (obs_vec() !== exp_vec()) begin
                    failures++;
                    $display("FAIL saturate_model a=%0d got=%h exp=%h", a, obs_vec(), exp_vec());
                end
            end
            vif.raw_loop = 1'b0;
            repeat (DEBOUNCE_CYC + $urandom_range(0, 3)) step();
        end
        repeat (8) step();
        checks++;
        if (vif.vehicle_count !== 8'd255) begin
            failures++;
            $display("FAIL saturate_count got=%0d exp=255", vif.vehicle_count);
        end
        $display("test_saturate done: count %0d", vif.vehicle_count);
    endtask

    initial begin
        test_reset();
        test_tick_idle();
        test_glitch();
        test_arm();
        test_service();
        test_reset_in_drain();
        test_random();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
